// File: rtl/user_flash_cache.sv
// Parametrised set-associative read cache in front of the Gowin user flash on the
// PicoRV32 bus. Also holds a behavioural stand-in for the Gowin_User_Flash macro.

module Gowin_User_Flash #(
    parameter int ROW_W = 9,
    parameter int COL_W = 6
) (
    input  logic             clk,
    input  logic             xe,
    input  logic             ye,
    input  logic             se,
    input  logic             prog,
    input  logic             erase,
    input  logic             nvstr,
    input  logic [ROW_W-1:0] xadr,
    input  logic [COL_W-1:0] yadr,
    input  logic [31:0]      din,
    output logic [31:0]      dout
);
    logic [ROW_W+COL_W-1:0] cellAddr;
    logic [31:0]            dout_q;

    assign cellAddr = {xadr, yadr};
    assign dout     = dout_q;

    // Array contents are a fixed function of the cell address; programming is not
    // modelled, so a program/erase cycle only echoes din onto dout.
    always_ff @(posedge clk) begin
        if (xe && ye && (prog || erase || nvstr))
            dout_q <= din;
        else if (xe && ye && se)
            dout_q <= {16'(cellAddr) ^ 16'hC0DE, 16'(cellAddr)};
    end
endmodule

module user_flash_cache #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 16,
    parameter int ROW_W      = 9,
    parameter int COL_W      = 6,
    parameter int ADDR_W     = ROW_W + COL_W,
    parameter int SE_CYCLES  = 1,
    parameter int RD_WAIT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              select,
    input  logic [3:0]        wstrb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_i,
    input  logic              invalidate,
    output logic              ready,
    output logic [31:0]       data_o,
    output logic              error,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int WORD_B = $clog2(LINE_WORDS);
    localparam int SET_B  = $clog2(SETS);
    localparam int WAY_B  = $clog2(WAYS);
    localparam int WB     = (WORD_B > 0) ? WORD_B : 1;
    localparam int SB     = (SET_B > 0) ? SET_B : 1;
    localparam int VB     = (WAY_B > 0) ? WAY_B : 1;
    localparam int TAG_W  = ADDR_W - WORD_B - SET_B;
    localparam int COLW   = WORD_B + 1;
    localparam int MAXW   = (SE_CYCLES > RD_WAIT) ? SE_CYCLES : RD_WAIT;
    localparam int CNT_W  = $clog2(MAXW + 1);
    localparam int DEPTH  = SETS * WAYS * LINE_WORDS;
    localparam int MIW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, SELECT, READ, STORE, FINISH, DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   reqAddr_q;
    logic [ADDR_W-1:0]   flashAddr_q;
    logic [VB-1:0]       fillWay_q;
    logic [COLW-1:0]     column_q;
    logic [CNT_W-1:0]    waitCnt_q;
    logic                xe_q, ye_q, se_q;
    logic                ready_q, error_q;
    logic [31:0]         data_q;
    logic [31:0]         hitCnt_q, missCnt_q;
    logic                flushPending_q;
    logic [WAYS-1:0]     valid_q  [SETS];
    logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
    logic [VB-1:0]       victim_q [SETS];
    logic [31:0]         lineMem  [DEPTH];

    logic [31:0]         flashDout;
    logic [WB-1:0]       reqWord, latWord;
    logic [SB-1:0]       reqSet, latSet;
    logic [TAG_W-1:0]    reqTag, latTag;
    logic                hitAny, haveInvalid;
    logic [VB-1:0]       hitWay, invalidWay;

    function automatic logic [MIW-1:0] memIndex(input logic [SB-1:0] s,
                                                input logic [VB-1:0] w,
                                                input logic [WB-1:0] wd);
        return MIW'((int'(s) * WAYS + int'(w)) * LINE_WORDS + int'(wd));
    endfunction

    function automatic logic [VB-1:0] nextWay(input logic [VB-1:0] w);
        return VB'((int'(w) + 1) % WAYS);
    endfunction

    function automatic logic [ADDR_W-1:0] lineBase(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LINE_WORDS - 1);
    endfunction

    assign reqWord = WB'(addr & ADDR_W'(LINE_WORDS - 1));
    assign reqSet  = SB'((addr >> WORD_B) & ADDR_W'(SETS - 1));
    assign reqTag  = TAG_W'(addr >> (WORD_B + SET_B));
    assign latWord = WB'(reqAddr_q & ADDR_W'(LINE_WORDS - 1));
    assign latSet  = SB'((reqAddr_q >> WORD_B) & ADDR_W'(SETS - 1));
    assign latTag  = TAG_W'(reqAddr_q >> (WORD_B + SET_B));

    // Tag lookup for the live bus address, plus the lowest empty way for a fill.
    always_comb begin
        hitAny      = 1'b0;
        hitWay      = '0;
        haveInvalid = 1'b0;
        invalidWay  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hitAny && valid_q[reqSet][w] && tag_q[reqSet][w] == reqTag) begin
                hitAny = 1'b1;
                hitWay = VB'(w);
            end
            if (!haveInvalid && !valid_q[reqSet][w]) begin
                haveInvalid = 1'b1;
                invalidWay  = VB'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == STORE)
            lineMem[memIndex(latSet, fillWay_q, column_q[WB-1:0])] <= flashDout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            reqAddr_q      <= '0;
            flashAddr_q    <= '0;
            fillWay_q      <= '0;
            column_q       <= '0;
            waitCnt_q      <= '0;
            xe_q           <= 1'b0;
            ye_q           <= 1'b0;
            se_q           <= 1'b0;
            ready_q        <= 1'b0;
            error_q        <= 1'b0;
            data_q         <= '0;
            hitCnt_q       <= '0;
            missCnt_q      <= '0;
            flushPending_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s]  <= '0;
                victim_q[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    tag_q[s][w] <= '0;
            end
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            // A flush requested mid-transaction waits for DONE so the fill still returns its data.
            if (invalidate && state_q != IDLE && state_q != DONE)
                flushPending_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (invalidate) begin
                        for (int s = 0; s < SETS; s++)
                            valid_q[s] <= '0;
                        flushPending_q <= 1'b0;
                    end else if (select) begin
                        reqAddr_q <= addr;
                        if (wstrb != 4'b0000) begin
                            error_q <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else if (hitAny) begin
                            data_q           <= lineMem[memIndex(reqSet, hitWay, reqWord)];
                            victim_q[reqSet] <= nextWay(hitWay);
                            hitCnt_q         <= hitCnt_q + 32'd1;
                            ready_q          <= 1'b1;
                            state_q          <= DONE;
                        end else begin
                            fillWay_q   <= haveInvalid ? invalidWay : victim_q[reqSet];
                            missCnt_q   <= missCnt_q + 32'd1;
                            column_q    <= '0;
                            flashAddr_q <= lineBase(addr);
                            xe_q        <= 1'b1;
                            ye_q        <= 1'b1;
                            state_q     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    se_q      <= 1'b1;
                    waitCnt_q <= CNT_W'(SE_CYCLES - 1);
                    state_q   <= SELECT;
                end
                SELECT: begin
                    if (waitCnt_q == '0) begin
                        se_q      <= 1'b0;
                        waitCnt_q <= CNT_W'(RD_WAIT - 1);
                        state_q   <= READ;
                    end else begin
                        waitCnt_q <= waitCnt_q - 1'b1;
                    end
                end
                READ: begin
                    if (waitCnt_q == '0) begin
                        xe_q    <= 1'b0;
                        ye_q    <= 1'b0;
                        state_q <= STORE;
                    end else begin
                        waitCnt_q <= waitCnt_q - 1'b1;
                    end
                end
                STORE: begin
                    column_q <= column_q + 1'b1;
                    if (int'(column_q) + 1 < LINE_WORDS) begin
                        flashAddr_q <= lineBase(reqAddr_q) | ADDR_W'(column_q + 1'b1);
                        xe_q        <= 1'b1;
                        ye_q        <= 1'b1;
                        state_q     <= LOAD;
                    end else begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    valid_q[latSet][fillWay_q] <= 1'b1;
                    tag_q[latSet][fillWay_q]   <= latTag;
                    victim_q[latSet]           <= nextWay(fillWay_q);
                    data_q                     <= lineMem[memIndex(latSet, fillWay_q, latWord)];
                    ready_q                    <= 1'b1;
                    state_q                    <= DONE;
                end
                DONE: begin
                    if (flushPending_q || invalidate) begin
                        for (int s = 0; s < SETS; s++)
                            valid_q[s] <= '0;
                    end
                    flushPending_q <= 1'b0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    Gowin_User_Flash #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_flash (
        .clk   (clk),
        .xe    (xe_q),
        .ye    (ye_q),
        .se    (se_q),
        .prog  (1'b0),
        .erase (1'b0),
        .nvstr (1'b0),
        .xadr  (flashAddr_q[ADDR_W-1:COL_W]),
        .yadr  (flashAddr_q[COL_W-1:0]),
        .din   (data_i),
        .dout  (flashDout)
    );

    assign ready      = ready_q;
    assign error      = error_q;
    assign data_o     = data_q;
    assign hit_count  = hitCnt_q;
    assign miss_count = missCnt_q;
endmodule

// File: tb/tb_user_flash_cache.sv
// Self-checking bench for user_flash_cache: default instance plus a 4-way/2-set
// instance, checked against an array-based cache model and the flash content rule.

module tb_user_flash_cache;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel0 = 1'b0, sel1 = 1'b0, inv0 = 1'b0, inv1 = 1'b0;
    logic [3:0]  ws0 = '0, ws1 = '0;
    logic [14:0] a0 = '0, a1 = '0;
    logic [31:0] di0 = '0, di1 = '0;
    logic        rdy0, rdy1, err0, err1;
    logic [31:0] q0, q1, hc0, hc1, mc0, mc1;

    int vectors = 0;
    int miscompares = 0;

    int cLW[2]   = '{16, 8};
    int cSets[2] = '{4, 2};
    int cWays[2] = '{2, 4};
    int cSE[2]   = '{1, 2};
    int cRD[2]   = '{1, 3};

    bit mValid[2][4][4];
    int mTag[2][4][4];
    int mVictim[2][4];
    int mHit[2];
    int mMiss[2];

    always #5 clk = ~clk;

    user_flash_cache dut0 (
        .clk(clk), .reset(reset), .select(sel0), .wstrb(ws0), .addr(a0), .data_i(di0),
        .invalidate(inv0), .ready(rdy0), .data_o(q0), .error(err0),
        .hit_count(hc0), .miss_count(mc0)
    );

    user_flash_cache #(
        .WAYS(4), .SETS(2), .LINE_WORDS(8), .SE_CYCLES(2), .RD_WAIT(3)
    ) dut1 (
        .clk(clk), .reset(reset), .select(sel1), .wstrb(ws1), .addr(a1), .data_i(di1),
        .invalidate(inv1), .ready(rdy1), .data_o(q1), .error(err1),
        .hit_count(hc1), .miss_count(mc1)
    );

    function automatic logic [31:0] flashWord(input int a);
        return {16'(a) ^ 16'hC0DE, 16'(a)};
    endfunction

    function automatic int missLat(input int d);
        return 2 + cLW[d] * (2 + cSE[d] + cRD[d]);
    endfunction

    function automatic void modelReset();
        for (int d = 0; d < 2; d++) begin
            mHit[d] = 0;
            mMiss[d] = 0;
            for (int s = 0; s < 4; s++) begin
                mVictim[d][s] = 0;
                for (int w = 0; w < 4; w++) begin
                    mValid[d][s][w] = 0;
                    mTag[d][s][w] = 0;
                end
            end
        end
    endfunction

    function automatic void modelFlush(input int d);
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 4; w++)
                mValid[d][s][w] = 0;
    endfunction

    // Reads a word through the model cache; returns 1 on a hit.
    function automatic bit modelAccess(input int d, input int a);
        int line = a / cLW[d];
        int s = line % cSets[d];
        int t = line / cSets[d];
        int fill = -1;
        for (int w = 0; w < cWays[d]; w++) begin
            if (mValid[d][s][w] && mTag[d][s][w] == t) begin
                mVictim[d][s] = (w + 1) % cWays[d];
                mHit[d]++;
                return 1'b1;
            end
        end
        for (int w = cWays[d] - 1; w >= 0; w--)
            if (!mValid[d][s][w]) fill = w;
        if (fill < 0) fill = mVictim[d][s];
        mValid[d][s][fill] = 1;
        mTag[d][s][fill] = t;
        mVictim[d][s] = (fill + 1) % cWays[d];
        mMiss[d]++;
        return 1'b0;
    endfunction

    task automatic drive(input int d, input logic s, input logic [3:0] w,
                         input int a, input logic inv);
        if (d == 0) begin
            sel0 = s; ws0 = w; a0 = 15'(a); inv0 = inv; di0 = $urandom;
        end else begin
            sel1 = s; ws1 = w; a1 = 15'(a); inv1 = inv; di1 = $urandom;
        end
    endtask

    task automatic sampleOuts(input int d, output logic r, output logic [31:0] q,
                              output logic e, output logic [31:0] hc, output logic [31:0] mc,
                              output logic xe, output logic se);
        if (d == 0) begin
            r = rdy0; q = q0; e = err0; hc = hc0; mc = mc0; xe = dut0.xe_q; se = dut0.se_q;
        end else begin
            r = rdy1; q = q1; e = err1; hc = hc1; mc = mc1; xe = dut1.xe_q; se = dut1.se_q;
        end
    endtask

    // One bus transaction with inline checks of latency, data, error and counters.
    // invAt: -1 none, 0 together with select, k>0 one-cycle pulse k cycles in.
    task automatic applyTxn(input int d, input int a, input logic [3:0] w, input int invAt,
                            output int seHigh, output bit xeSeen);
        logic r, e, xe, se;
        logic [31:0] q, hc, mc, prevQ, expQ;
        int lat, expLat;
        bit hit, expErr, flushAfter;
        sampleOuts(d, r, prevQ, e, hc, mc, xe, se);
        flushAfter = 0;
        if (w != 4'b0000) begin
            expLat = 1; expErr = 1; expQ = prevQ;
        end else begin
            if (invAt == 0) modelFlush(d);
            hit = modelAccess(d, a);
            expLat = hit ? 1 : missLat(d) + ((invAt == 0) ? 1 : 0);
            expErr = 0;
            expQ = flashWord(a);
            flushAfter = (invAt > 0 && invAt < expLat);
        end
        drive(d, 1'b1, w, a, invAt == 0);
        lat = 0; seHigh = 0; xeSeen = 0;
        while (lat < 1000) begin
            @(posedge clk); #1;
            lat++;
            drive(d, 1'b1, w, a, lat == invAt);
            sampleOuts(d, r, q, e, hc, mc, xe, se);
            if (se) seHigh++;
            if (xe) xeSeen = 1;
            if (r) break;
        end
        drive(d, 1'b0, 4'b0000, a, 1'b0);
        if (flushAfter) modelFlush(d);
        vectors++;
        if (lat !== expLat) begin
            miscompares++;
            $display("[TB] FAIL latency d%0d addr=%h: got %0d cycles, want %0d", d, a, lat, expLat);
        end
        vectors++;
        if (q !== expQ) begin
            miscompares++;
            $display("[TB] FAIL data_o d%0d addr=%h: got %h, want %h", d, a, q, expQ);
        end
        vectors++;
        if (e !== expErr) begin
            miscompares++;
            $display("[TB] FAIL error d%0d addr=%h: got %b, want %b", d, a, e, expErr);
        end
        vectors++;
        if (hc !== 32'(mHit[d]) || mc !== 32'(mMiss[d])) begin
            miscompares++;
            $display("[TB] FAIL counters d%0d addr=%h: got hit=%0d miss=%0d, want hit=%0d miss=%0d",
                     d, a, hc, mc, mHit[d], mMiss[d]);
        end
        @(posedge clk); #1;
        sampleOuts(d, r, q, e, hc, mc, xe, se);
        vectors++;
        if (r !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ready_pulse d%0d addr=%h: got ready=%b one cycle later, want 0", d, a, r);
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        drive(0, 1'b0, 4'b0000, 0, 1'b0);
        drive(1, 1'b0, 4'b0000, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        logic r, e, xe, se;
        logic [31:0] q, hc, mc;
        resetDut();
        for (int d = 0; d < 2; d++) begin
            sampleOuts(d, r, q, e, hc, mc, xe, se);
            vectors++;
            if ({r, e, xe, se} !== 4'b0000 || q !== 32'h0 || hc !== 32'h0 || mc !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_state d%0d: got ready=%b err=%b xe=%b se=%b data=%h hit=%0d miss=%0d, want all 0",
                         d, r, e, xe, se, q, hc, mc);
            end
        end
    endtask

    task automatic test_miss_then_hit();
        int seHigh; bit xeSeen;
        applyTxn(0, 'h0013, 4'b0000, -1, seHigh, xeSeen);
        vectors++;
        if (seHigh !== 16) begin
            miscompares++;
            $display("[TB] FAIL se_cycles d0: got %0d cycles of se, want 16", seHigh);
        end
        applyTxn(0, 'h0010, 4'b0000, -1, seHigh, xeSeen);
    endtask

    task automatic test_replacement();
        int seHigh; bit xeSeen;
        resetDut();
        applyTxn(0, 'h0000, 4'b0000, -1, seHigh, xeSeen);
        applyTxn(0, 'h0040, 4'b0000, -1, seHigh, xeSeen);
        applyTxn(0, 'h0000, 4'b0000, -1, seHigh, xeSeen);
        applyTxn(0, 'h0080, 4'b0000, -1, seHigh, xeSeen);
        applyTxn(0, 'h0000, 4'b0000, -1, seHigh, xeSeen);
        applyTxn(0, 'h0040, 4'b0000, -1, seHigh, xeSeen);
        vectors++;
        if (hc0 !== 32'd2 || mc0 !== 32'd4) begin
            miscompares++;
            $display("[TB] FAIL replace_totals: got hit=%0d miss=%0d, want hit=2 miss=4", hc0, mc0);
        end
    endtask

    task automatic test_write_error();
        int seHigh; bit xeSeen;
        applyTxn(0, 'h0005, 4'hF, -1, seHigh, xeSeen);
        vectors++;
        if (xeSeen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL write_no_flash: got xe asserted=%b, want 0", xeSeen);
        end
    endtask

    task automatic test_invalidate_idle();
        int seHigh; bit xeSeen;
        applyTxn(0, 'h0000, 4'b0000, -1, seHigh, xeSeen);
        applyTxn(0, 'h0001, 4'b0000, 0, seHigh, xeSeen);
    endtask

    task automatic test_invalidate_midfill();
        int seHigh; bit xeSeen;
        applyTxn(0, 'h0100, 4'b0000, 20, seHigh, xeSeen);
        applyTxn(0, 'h0100, 4'b0000, -1, seHigh, xeSeen);
    endtask

    task automatic test_reset_midfill();
        logic r, e, xe, se;
        logic [31:0] q, hc, mc;
        int seHigh; bit xeSeen, sawReady;
        drive(0, 1'b1, 4'b0000, 'h0200, 1'b0);
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        drive(0, 1'b0, 4'b0000, 'h0200, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        modelReset();
        sampleOuts(0, r, q, e, hc, mc, xe, se);
        vectors++;
        if ({xe, dut0.ye_q, se, r} !== 4'b0000 || hc !== 32'h0 || mc !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_midfill: got xe=%b ye=%b se=%b ready=%b hit=%0d miss=%0d, want all 0",
                     xe, dut0.ye_q, se, r, hc, mc);
        end
        sawReady = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (rdy0) sawReady = 1;
        end
        vectors++;
        if (sawReady !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_no_ready: got ready after aborted fill=%b, want 0", sawReady);
        end
        applyTxn(0, 'h0200, 4'b0000, -1, seHigh, xeSeen);
    endtask

    task automatic test_sweep();
        int seHigh; bit xeSeen;
        applyTxn(1, 'h0000, 4'b0000, -1, seHigh, xeSeen);
        vectors++;
        if (seHigh !== 16) begin
            miscompares++;
            $display("[TB] FAIL se_cycles d1: got %0d cycles of se, want 16", seHigh);
        end
        for (int i = 1; i < 5; i++)
            applyTxn(1, i * 16, 4'b0000, -1, seHigh, xeSeen);
        for (int i = 1; i < 5; i++)
            applyTxn(1, i * 16 + 3, 4'b0000, -1, seHigh, xeSeen);
        applyTxn(1, 'h0000, 4'b0000, -1, seHigh, xeSeen);
        vectors++;
        if (hc1 !== 32'd4 || mc1 !== 32'd6) begin
            miscompares++;
            $display("[TB] FAIL sweep_totals: got hit=%0d miss=%0d, want hit=4 miss=6", hc1, mc1);
        end
    endtask

    task automatic test_random();
        int seHigh, a; bit xeSeen;
        for (int n = 0; n < 40; n++) begin
            a = $urandom_range(0, 7) * 64 + $urandom_range(0, 3) * 16 + $urandom_range(0, 15);
            if ($urandom_range(0, 5) == 0)
                applyTxn(0, a, 4'($urandom_range(1, 15)), -1, seHigh, xeSeen);
            else
                applyTxn(0, a, 4'b0000, -1, seHigh, xeSeen);
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_miss_then_hit();
        test_replacement();
        test_write_error();
        test_invalidate_idle();
        test_invalidate_midfill();
        test_reset_midfill();
        test_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
